edge_frame_sequencer: RTL and testbench

//  Master sequencer for the Sobel edge datapath. On Start it reads one frame from a
//  1-cycle-latency frame store and drives it as a gap-free raster. It generates the

---
 rtl/edge_pkg.sv | 23 ++
 rtl/edge_seq_counter.sv | 45 ++++
 rtl/edge_frame_sequencer.sv | 165 ++++++++++++++++
 tb/tb_edge_frame_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared types and constants for the Sobel edge frame sequencer.
package edge_pkg;

    // Pixel sample width on the frame-store and datapath side
    localparam int PIX_W = 8;

    // Width of the frame Width/Height fields
    localparam int DIM_W = 8;

    // Smallest frame the 3x3 kernel can process in either dimension
    localparam int MIN_DIM = 3;

    // Zero-pixel cycles needed to drain the datapath delay line after the last pixel
    localparam int DEFAULT_FLUSH_LEN = 504;

    // Sequencer states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } seq_state_t;

endpackage

// File: rtl/edge_seq_counter.sv
// Raster position counter: column, row and linear frame-store address.
module edge_seq_counter
    import edge_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              clear,
    input  logic              enable,
    input  logic [DIM_W-1:0]  width,
    input  logic [DIM_W-1:0]  height,
    output logic [ADDR_W-1:0] addr,
    output logic              last_col,
    output logic              last_pixel
);

    localparam logic [DIM_W-1:0] DIM_ONE = DIM_W'(1);

    logic [DIM_W-1:0]  col_reg;
    logic [DIM_W-1:0]  row_reg;
    logic [ADDR_W-1:0] addr_reg;

    assign last_col   = (col_reg == (width - DIM_ONE));
    assign last_pixel = last_col && (row_reg == (height - DIM_ONE));
    assign addr       = addr_reg;

    // Step one pixel per enabled cycle; the address runs linearly and never wraps
    always_ff @(posedge Clk) begin
        if (Reset || clear) begin
            col_reg  <= '0;
            row_reg  <= '0;
            addr_reg <= '0;
        end else if (enable) begin
            addr_reg <= addr_reg + ADDR_W'(1);
            if (last_col) begin
                col_reg <= '0;
                row_reg <= row_reg + DIM_ONE;
            end else begin
                col_reg <= col_reg + DIM_ONE;
            end
        end
    end

endmodule

// File: rtl/edge_frame_sequencer.sv
// Reads one frame from a 1-cycle-latency store and streams it gap-free into the
// Sobel datapath with frame/line strobes, then flushes the datapath delay line.
module edge_frame_sequencer #(
    parameter int ADDR_W    = 16,
    parameter int FLUSH_LEN = edge_pkg::DEFAULT_FLUSH_LEN,
    parameter int MIN_DIM   = edge_pkg::MIN_DIM
) (
    input  logic                      Clk,
    input  logic                      Reset,
    input  logic                      Start,
    input  logic [edge_pkg::DIM_W-1:0] Width,
    input  logic [edge_pkg::DIM_W-1:0] Height,
    output logic                      RdEn,
    output logic [ADDR_W-1:0]         RdAddr,
    input  logic [edge_pkg::PIX_W-1:0] RdData,
    output logic [edge_pkg::PIX_W-1:0] PixelOut,
    output logic                      FrameOut,
    output logic                      LineOut,
    output logic [edge_pkg::DIM_W-1:0] WidthOut,
    output logic                      Busy,
    output logic                      Done,
    output logic                      Err
);

    localparam int DW   = edge_pkg::DIM_W;
    localparam int PW   = edge_pkg::PIX_W;
    localparam int FC_W = $clog2(FLUSH_LEN + 1);

    localparam logic [FC_W-1:0] FLUSH_LAST = FC_W'(FLUSH_LEN);
    localparam logic [DW-1:0]   MIN_DIM_V  = DW'(MIN_DIM);

    edge_pkg::seq_state_t state_reg, state_next;

    logic [DW-1:0]     width_reg;
    logic [DW-1:0]     height_reg;
    logic [FC_W-1:0]   flush_cnt_reg, flush_cnt_next;
    logic              err_reg, err_next;
    logic              done_reg, done_next;
    logic              accept;
    logic              cnt_en;
    logic              rd_en;
    logic [ADDR_W-1:0] addr;
    logic              last_col;
    logic              last_pixel;
    logic              line_start_reg;
    logic              valid_d1_reg;
    logic [1:0]        flag_pipe_reg [0:1];   // bit 1 = frame start, bit 0 = line start
    logic [PW-1:0]     pixel_reg;

    edge_seq_counter #(
        .ADDR_W (ADDR_W)
    ) u_counter (
        .Clk        (Clk),
        .Reset      (Reset),
        .clear      (accept),
        .enable     (cnt_en),
        .width      (width_reg),
        .height     (height_reg),
        .addr       (addr),
        .last_col   (last_col),
        .last_pixel (last_pixel)
    );

    assign rd_en    = (state_reg == edge_pkg::READ);
    assign RdEn     = rd_en;
    assign RdAddr   = rd_en ? addr : '0;
    assign Busy     = (state_reg != edge_pkg::IDLE);
    assign Done     = done_reg;
    assign Err      = err_reg;
    assign WidthOut = width_reg;
    assign PixelOut = pixel_reg;
    assign FrameOut = flag_pipe_reg[1][1];
    assign LineOut  = flag_pipe_reg[1][0];

    // Next-state logic: accept/reject Start, run the raster, count the flush
    always_comb begin
        state_next     = state_reg;
        flush_cnt_next = flush_cnt_reg;
        err_next       = 1'b0;
        done_next      = 1'b0;
        accept         = 1'b0;
        cnt_en         = 1'b0;
        case (state_reg)
            edge_pkg::IDLE: begin
                if (Start) begin
                    if ((Width < MIN_DIM_V) || (Height < MIN_DIM_V)) begin
                        err_next = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        state_next = edge_pkg::READ;
                    end
                end
            end
            edge_pkg::READ: begin
                cnt_en         = 1'b1;
                flush_cnt_next = '0;
                if (last_pixel) begin
                    state_next = edge_pkg::FLUSH;
                end
            end
            edge_pkg::FLUSH: begin
                // The first FLUSH cycles still carry the last two pixels out of the
                // output pipeline, so counting to FLUSH_LEN lands Done FLUSH_LEN
                // cycles after the last valid PixelOut.
                if (flush_cnt_reg == FLUSH_LAST) begin
                    done_next  = 1'b1;
                    state_next = edge_pkg::IDLE;
                end else begin
                    flush_cnt_next = flush_cnt_reg + FC_W'(1);
                end
            end
            default: begin
                state_next = edge_pkg::IDLE;
            end
        endcase
    end

    // State, frame size latches, flush counter and status pulses
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_reg     <= edge_pkg::IDLE;
            width_reg     <= '0;
            height_reg    <= '0;
            flush_cnt_reg <= '0;
            err_reg       <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            flush_cnt_reg <= flush_cnt_next;
            err_reg       <= err_next;
            done_reg      <= done_next;
            if (accept) begin
                width_reg  <= Width;
                height_reg <= Height;
            end
        end
    end

    // Marks that the next read is column 0 of a row
    always_ff @(posedge Clk) begin
        if (Reset) begin
            line_start_reg <= 1'b0;
        end else if (accept) begin
            line_start_reg <= 1'b1;
        end else if (cnt_en) begin
            line_start_reg <= last_col;
        end
    end

    // Two-stage alignment so strobes coincide with the registered store data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            valid_d1_reg     <= 1'b0;
            flag_pipe_reg[0] <= '0;
            flag_pipe_reg[1] <= '0;
            pixel_reg        <= '0;
        end else begin
            valid_d1_reg     <= rd_en;
            flag_pipe_reg[0] <= {rd_en && (addr == '0), rd_en && line_start_reg};
            flag_pipe_reg[1] <= flag_pipe_reg[0];
            pixel_reg        <= valid_d1_reg ? RdData : '0;
        end
    end

endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Self-checking bench for edge_frame_sequencer: vector table of frames plus
// hand-written reset sequences.
module tb_edge_frame_sequencer;
    import edge_pkg::*;

    localparam int ADDR_W    = 16;
    localparam int FLUSH_LEN = DEFAULT_FLUSH_LEN;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        width;
    logic [7:0]        height;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data = '0;
    logic [7:0]        pixel_out;
    logic              frame_out;
    logic              line_out;
    logic [7:0]        width_out;
    logic              busy;
    logic              done;
    logic              err;

    logic [7:0] mem [0:65535];

    int n_cmp      = 0;
    int n_bad      = 0;
    int prev_width = 0;

    typedef struct {
        int w;
        int h;
        bit hold;        // keep Start high for the whole frame
        int exp_err;     // 1 when the size must be rejected
        int exp_reads;
        int exp_last;    // last RdAddr seen with RdEn
        int exp_lines;
    } frame_vec_t;

    frame_vec_t vecs [0:7];

    edge_frame_sequencer #(
        .ADDR_W    (ADDR_W),
        .FLUSH_LEN (FLUSH_LEN),
        .MIN_DIM   (MIN_DIM)
    ) dut (
        .Clk      (clk),
        .Reset    (reset),
        .Start    (start),
        .Width    (width),
        .Height   (height),
        .RdEn     (rd_en),
        .RdAddr   (rd_addr),
        .RdData   (rd_data),
        .PixelOut (pixel_out),
        .FrameOut (frame_out),
        .LineOut  (line_out),
        .WidthOut (width_out),
        .Busy     (busy),
        .Done     (done),
        .Err      (err)
    );

    always #5 clk = ~clk;

    // Frame store model with one cycle of read latency
    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input int exp_wout);
        chk({tag, "_rden"},   64'(rd_en),     64'd0);
        chk({tag, "_rdaddr"}, 64'(rd_addr),   64'd0);
        chk({tag, "_pixel"},  64'(pixel_out), 64'd0);
        chk({tag, "_frame"},  64'(frame_out), 64'd0);
        chk({tag, "_line"},   64'(line_out),  64'd0);
        chk({tag, "_busy"},   64'(busy),      64'd0);
        chk({tag, "_done"},   64'(done),      64'd0);
        chk({tag, "_err"},    64'(err),       64'd0);
        chk({tag, "_wout"},   64'(width_out), 64'(exp_wout));
    endtask

    // Launch one Start and check every output cycle by cycle against the raster model
    task automatic run_vec(input int idx, input frame_vec_t v);
        int n_pix;
        int done_n;
        int last_n;
        int k;
        int exp_wout;
        int m_rd = 0, m_addr = 0, m_pix = 0, m_frame = 0, m_line = 0;
        int m_busy = 0, m_done = 0, m_err = 0, m_wout = 0;
        int reads = 0, lines = 0, frames = 0, dones = 0, errs = 0;
        int last_addr = 0;
        int first_bad = -1;
        logic e_rd, e_pv, e_frame, e_line, e_busy, e_done, e_err;
        logic [15:0] e_addr;
        logic [7:0]  e_pix;
        bit bad;

        n_pix    = v.w * v.h;
        done_n   = (v.exp_err != 0) ? 0 : n_pix + 2 + FLUSH_LEN;
        last_n   = (v.exp_err != 0) ? 4 : done_n + 1;
        exp_wout = (v.exp_err != 0) ? prev_width : v.w;

        @(negedge clk);
        start  = 1'b1;
        width  = 8'(v.w);
        height = 8'(v.h);
        for (int n = 1; n <= last_n; n++) begin
            @(negedge clk);
            start   = v.hold && (n < done_n);
            k       = n - 3;
            e_rd    = (v.exp_err == 0) && (n <= n_pix);
            e_addr  = e_rd ? 16'(n - 1) : 16'd0;
            e_pv    = (v.exp_err == 0) && (k >= 0) && (k < n_pix);
            e_pix   = e_pv ? 8'(k) : 8'd0;
            e_frame = e_pv && (k == 0);
            e_line  = e_pv && ((k % v.w) == 0);
            e_busy  = (v.exp_err == 0) && (n < done_n);
            e_done  = (v.exp_err == 0) && (n == done_n);
            e_err   = (v.exp_err != 0) && (n == 1);
            bad = 1'b0;
            if (rd_en !== e_rd)              begin m_rd++;    bad = 1'b1; end
            if (rd_addr !== e_addr)          begin m_addr++;  bad = 1'b1; end
            if (pixel_out !== e_pix)         begin m_pix++;   bad = 1'b1; end
            if (frame_out !== e_frame)       begin m_frame++; bad = 1'b1; end
            if (line_out !== e_line)         begin m_line++;  bad = 1'b1; end
            if (busy !== e_busy)             begin m_busy++;  bad = 1'b1; end
            if (done !== e_done)             begin m_done++;  bad = 1'b1; end
            if (err !== e_err)               begin m_err++;   bad = 1'b1; end
            if (width_out !== 8'(exp_wout))  begin m_wout++;  bad = 1'b1; end
            if (bad && first_bad < 0) first_bad = n;
            if (rd_en === 1'b1) begin
                reads++;
                last_addr = int'(rd_addr);
            end
            if (line_out === 1'b1)  lines++;
            if (frame_out === 1'b1) frames++;
            if (done === 1'b1)      dones++;
            if (err === 1'b1)       errs++;
        end

        chk($sformatf("v%0d_rden_cycles", idx),  64'(m_rd),    64'd0);
        chk($sformatf("v%0d_rdaddr_cycles", idx), 64'(m_addr), 64'd0);
        chk($sformatf("v%0d_pixel_cycles", idx), 64'(m_pix),   64'd0);
        chk($sformatf("v%0d_frame_cycles", idx), 64'(m_frame), 64'd0);
        chk($sformatf("v%0d_line_cycles", idx),  64'(m_line),  64'd0);
        chk($sformatf("v%0d_busy_cycles", idx),  64'(m_busy),  64'd0);
        chk($sformatf("v%0d_done_cycles", idx),  64'(m_done),  64'd0);
        chk($sformatf("v%0d_err_cycles", idx),   64'(m_err),   64'd0);
        chk($sformatf("v%0d_wout_cycles", idx),  64'(m_wout),  64'd0);
        chk($sformatf("v%0d_reads", idx),     64'(reads),     64'(v.exp_reads));
        chk($sformatf("v%0d_last_addr", idx), 64'(last_addr), 64'(v.exp_last));
        chk($sformatf("v%0d_lines", idx),     64'(lines),     64'(v.exp_lines));
        chk($sformatf("v%0d_frames", idx),    64'(frames),    64'((v.exp_err != 0) ? 0 : 1));
        chk($sformatf("v%0d_dones", idx),     64'(dones),     64'((v.exp_err != 0) ? 0 : 1));
        chk($sformatf("v%0d_errs", idx),      64'(errs),      64'(v.exp_err));
        $display("frame %0d: W=%0d H=%0d hold=%0d reads=%0d last_addr=%0d lines=%0d done=%0d err=%0d first_bad_cycle=%0d",
                 idx, v.w, v.h, v.hold, reads, last_addr, lines, dones, errs, first_bad);
        prev_width = exp_wout;
    endtask

    // Watchdog: the whole run is bounded well below this
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //         w    h   hold err reads  last   lines
        vecs[0] = '{4,   3,   1'b0, 0, 12,    11,    3};
        vecs[1] = '{2,   5,   1'b0, 1, 0,     0,     0};
        vecs[2] = '{6,   3,   1'b1, 0, 18,    17,    3};
        vecs[3] = '{3,   4,   1'b0, 0, 12,    11,    4};
        vecs[4] = '{5,   2,   1'b0, 1, 0,     0,     0};
        vecs[5] = '{8,   8,   1'b0, 0, 64,    63,    8};
        vecs[6] = '{3,   3,   1'b0, 0, 9,     8,     3};
        vecs[7] = '{255, 255, 1'b0, 0, 65025, 65024, 255};

        for (int i = 0; i < 65536; i++) mem[i] = i[7:0];

        reset  = 1'b1;
        start  = 1'b0;
        width  = '0;
        height = '0;
        repeat (3) @(negedge clk);
        chk_idle("in_reset", 0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("after_reset", 0);

        // Start together with Reset: Reset wins
        start  = 1'b1;
        width  = 8'd8;
        height = 8'd8;
        reset  = 1'b1;
        @(negedge clk);
        chk_idle("rst_and_start", 0);
        start = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk_idle("rst_and_start_after", 0);
        $display("sequence reset_with_start: busy=%0d width_out=%0d", busy, width_out);

        // Reset in the middle of an 8x8 frame, while reading row 1 col 2
        start  = 1'b1;
        width  = 8'd8;
        height = 8'd8;
        for (int n = 1; n <= 11; n++) begin
            @(negedge clk);
            start = 1'b0;
        end
        chk("midrst_pre_addr",  64'(rd_addr),   64'd10);
        chk("midrst_pre_busy",  64'(busy),      64'd1);
        chk("midrst_pre_pixel", 64'(pixel_out), 64'd8);
        chk("midrst_pre_line",  64'(line_out),  64'd1);
        chk("midrst_pre_wout",  64'(width_out), 64'd8);
        reset = 1'b1;
        @(negedge clk);
        chk_idle("midrst", 0);
        reset = 1'b0;
        @(negedge clk);
        chk_idle("midrst_after", 0);
        $display("sequence mid_frame_reset: busy=%0d rd_en=%0d pixel=%0d", busy, rd_en, pixel_out);
        prev_width = 0;

        for (int i = 0; i < 8; i++) begin
            run_vec(i, vecs[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
